// File: rtl/noc_tx_packetizer_if.sv
// PE-side word handshake plus the router-side 4-phase bundled-data channel
// of the NoC transmit packetizer.
interface noc_tx_packetizer_if #(
    parameter int unsigned WIDTH = 9
);
    logic             pe_valid;
    logic             pe_ready;
    logic [3:0]       pe_dest;
    logic [3:0]       pe_data;
    logic             out_req;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;

    modport master (
        output pe_valid, pe_dest, pe_data, out_ack,
        input  pe_ready, out_req, out_data
    );

    modport slave (
        input  pe_valid, pe_dest, pe_data, out_ack,
        output pe_ready, out_req, out_data
    );
endinterface

// File: rtl/noc_tx_packetizer.sv
// Buffers PE dest/payload words, forms parity-protected packets and sends
// them over a 4-phase req/ack channel with a synchronized returning ack.
module noc_tx_packetizer #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    noc_tx_packetizer_if.slave   bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     sent_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned AW    = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] wr_pkt;
    logic             ack_meta;
    logic             ack_s;
    logic             req_q;
    logic [WIDTH-1:0] data_q;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push       = bus.pe_valid & ~fifo_full;
    assign pop        = (state == IDLE) & ~fifo_empty;
    assign wr_pkt     = WIDTH'({bus.pe_dest, bus.pe_data, ^{bus.pe_dest, bus.pe_data}});

    assign bus.pe_ready = ~fifo_full;
    assign bus.out_req  = req_q;
    assign bus.out_data = data_q;
    assign busy         = (state != IDLE) | ~fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= wr_pkt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Two-flop synchronizer; the FSM only ever looks at ack_s.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= bus.out_ack;
            ack_s    <= ack_meta;
        end
    end

    // Ack levels other than the one each state waits for are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            sent_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        data_q <= mem[rd_ptr[PTR_W-1:0]];
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    req_q <= 1'b1;
                    state <= REQ;
                end
                REQ: begin
                    if (ack_s) begin
                        req_q <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        sent_count <= sent_count + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/noc_tx_packetizer.md
Name: noc_tx_packetizer

Overview:
- Clocked network interface feeding a leaf input port (C1in/C2in) of the asynchronous tree router.
- Accepts dest/payload words from a synchronous processing element (PE) and buffers them in a small FIFO.
- Forms the 9-bit packet: dest[8:5], payload[4:1], parity[0].
- Drives each packet onto a 4-phase bundled-data req/ack channel toward the router, with a 2-flop synchronizer on the returning ack.

Parameters:
- WIDTH, 9, packet width; fixed layout {dest[3:0], payload[3:0], parity}.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the sent-packet counter.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- pe_valid  input  1  PE offers a word this cycle.
- pe_ready  output  1  block can accept a word; equals !fifo_full.
- pe_dest  input  4  destination leaf address, goes to packet[8:5].
- pe_data  input  4  payload, goes to packet[4:1].
- out_req  output  1  bundled-data request to the router.
- out_data  output  WIDTH  packet; registered, stable whenever out_req=1.
- out_ack  input  1  router acknowledge; asynchronous to clk.
- busy  output  1  FIFO non-empty or FSM not in IDLE.
- sent_count  output  CNT_W  number of completed 4-phase transfers; wraps modulo 2^CNT_W.

Behaviour:
- Clock/reset: already decided — one clock, clk; reset is asynchronous and active-high.
- While reset=1 (applies immediately, including mid-handshake):
  - FIFO empty, FSM=IDLE, out_req=0, out_data=0.
  - sync flops=0, sent_count=0, busy=0, pe_ready=1.
- Parity: packet[0] = XOR of packet[8:1], computed at FIFO write. A downstream parity checker therefore reports no error.
- PE handshake:
  - Word accepted at a rising edge where pe_valid & pe_ready.
  - pe_ready=0 when FIFO full, even if a pop occurs in the same cycle. No bypass.
- Ack synchronizer: ack_s = out_ack delayed through 2 flops. The FSM uses only ack_s.
- FSM, one transition per edge:
  - IDLE: if FIFO non-empty, load out_data <= head, pop FIFO, go to SETUP.
  - SETUP: out_req <= 1, go to REQ. This gives one full cycle of data setup before req.
  - REQ: hold out_req=1 and out_data until ack_s=1. Then out_req <= 0, go to RELEASE.
  - RELEASE: wait for ack_s=0. Then increment sent_count and go to IDLE.
- out_data holds its value after the transfer until the next load; it is not cleared.
- Latency from an empty, idle state:
  - Word accepted at edge N; out_data valid after N+1; out_req rises after N+2.
  - Transfer time = 2 + 2-flop sync delay per ack edge + router response time.
- Throughput: at most one packet per 4-phase cycle (>= 6 clk edges with an immediate ack).
- FIFO: circular pointers wrap at DEPTH with an explicit full/empty distinction.
  - Push and pop in the same edge are permitted when neither full nor empty.
  - Pop in IDLE with a simultaneous push when the FIFO holds 1 entry leaves it holding 1 entry.
- Protocol violations (ack rising in IDLE/SETUP, or falling in REQ) are ignored. FSM state only advances on the expected ack level.
- busy = (FSM != IDLE) | !fifo_empty.

Test Plan:
- Reset then single word dest=4'b0110, data=4'b1011 -> out_data=9'b0110_1011_1 (parity=1), out_req high 2 edges after acceptance; ack responder returns ack 1 cycle after req edges -> sent_count=1, busy=0 at end.
- Parity check over all 256 dest/data combinations -> ^out_data[8:0]==0 for every transfer.
- Hold ack low, push 5 words with DEPTH=4 -> 1 word in flight, 4 queued, pe_ready=0 after 5th acceptance; then release ack -> all 5 emerge in order, pe_ready returns 1 after first pop.
- Assert reset while out_req=1 and out_ack=1 -> out_req=0 immediately (asynchronous), FIFO empty, sent_count=0; after reset, a new word transfers normally once out_ack returns to 0.
- Glitch stimulus: pulse out_ack while in IDLE with FIFO empty -> no state change, sent_count unchanged.
- 300 back-to-back transfers with CNT_W=8 -> sent_count wraps 255->0 and ends at 44.
